snake_game_sched: RTL and testbench
===================================

// Module: snake_game_sched
// PURPOSE
//  Game-step scheduler and configurator for the snake datapath. Paces game steps, arbitrates
//  button presses into one legal direction per step, and hands it to the snake engine with a
//  step_req/step_done handshake. Tracks score and places a new apple on a free cell after each
//  eat, reading the engine's 9x8-bit body vector. Sits between the button inputs and the engine.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per step at score 0 (>= 2)
//  SPEED_DEC  1_000_000   cycles removed from the step period per point scored
//  MIN_DIV    10_000_000  floor of the step period (<= TICK_DIV)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  btn_up/btn_down/btn_left/btn_right  in 1  debounced 1-cycle press pulses
//  start      in   1   pulse: leave IDLE/OVER and start a game
//  pause      in   1   pulse: toggle RUN<->PAUSE
//  snake      in   72  body cells, [71:64]=head, 8'd0 = unused segment
//  step_done  in   1   engine finished the step (1-cycle pulse)
//  ate        in   1   valid with step_done: head landed on apple
//  dead       in   1   valid with step_done: wall/body collision
//  step_req   out  1   1-cycle pulse: engine executes one move using dir
//  dir        out  2   0=up 1=down 2=left 3=right; stable from step_req to step_done
//  apple      out  8   apple cell (tens=row, units=col)
//  apple_vld  out  1   apple is valid; low while PLACE runs
//  score      out  8   points, saturating at 255
//  state_o    out  3   current FSM state, for display/debug
// BEHAVIOUR
//  Reset (any state, overrides all inputs): state=IDLE, step_req=0, dir=3 (right),
//   pending dir=3, apple=8'd89, apple_vld=1, score=0, tick counter=0, LFSR=8'h01, pause_pend=0.
//  Valid cell: 12..89, units digit 2..9.
//  FSM states: IDLE=0 RUN=1 STEP=2 PLACE=3 PAUSE=4 OVER=5.
//   IDLE:  start -> RUN (counter=0, score=0, dir=3).
//   RUN:   counter increments. At period-1: step_req=1 for 1 cycle, dir<=pending, go to STEP.
//          pause -> PAUSE, counter held.
//   STEP:  wait for step_done; no timeout.
//          dead -> OVER, dominates ate.
//          ate -> score+1 (saturating), apple_vld=0, go to PLACE.
//          otherwise -> RUN, counter=0.
//   PLACE: try an LFSR candidate, compare it against all 9 segments (1 segment/cycle,
//          segments == 0 skipped).
//          Invalid cell or any match -> advance LFSR, retry.
//          Pass -> apple<=candidate, apple_vld=1, -> RUN, counter=0.
//          LFSR is 8-bit maximal, x^8+x^6+x^5+x^4+1, and free-runs in every state.
//   PAUSE: pause -> RUN, counter resumes from the held value.
//   OVER:  outputs hold. start -> reset-equivalent reinit -> RUN.
//  Period = max(TICK_DIV - score*SPEED_DEC, MIN_DIV), computed with a 32-bit no-underflow
//   subtract. A score change takes effect from the next RUN entry.
//  Direction arbitration:
//   - Same-cycle presses: priority up>down>left>right.
//   - A press reversing the committed dir (up<->down, left<->right) is ignored.
//   - Last legal press before step_req wins; it is committed at step_req.
//   - Presses during STEP are held and apply to the next step.
//  pause in STEP/PLACE: sets pause_pend; taken on entry to RUN (-> PAUSE immediately,
//   no tick). pause in IDLE/OVER: ignored. start in RUN/STEP/PLACE/PAUSE: ignored.
//  step_done outside STEP: ignored.
//  Worst-case PLACE latency is bounded by 255*10 cycles.
// TESTING (TICK_DIV=8, SPEED_DEC=2, MIN_DIV=4)
//  rst, start, no buttons -> step_req pulses every 8 cycles with dir=3; score=0; apple=89.
//  btn_left while dir=3 -> dir stays 3. btn_up+btn_left same cycle -> next step_req has dir=0.
//  step_done+ate x3 -> score=3, period becomes 4 (floored, not 2); each eat:
//   apple_vld low, new apple valid and not equal to any nonzero snake byte.
//  step_done with ate=1 and dead=1 -> OVER, score unchanged; start -> RUN, score=0, apple=89.
//  pause in STEP -> after step_done, state=PAUSE with no extra step_req; pause -> RUN resumes.
//  rst asserted in PLACE -> next cycle all outputs at reset values, state_o=0.

Source files
------------

// File: rtl/snake_game_sched.sv
// Game-step scheduler: paces snake steps, turns button presses into one legal direction per step,
// keeps score and places a fresh apple on a free cell (one body segment checked per cycle).
module snake_game_sched #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned SPEED_DEC = 1_000_000,
    parameter int unsigned MIN_DIV   = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        start,
    input  logic        pause,
    input  logic [71:0] snake,
    input  logic        step_done,
    input  logic        ate,
    input  logic        dead,
    output logic        step_req,
    output logic [1:0]  dir,
    output logic [7:0]  apple,
    output logic        apple_vld,
    output logic [7:0]  score,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_PLACE = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [7:0] APPLE_RST = 8'd89;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    state_t      state_q, state_d;
    logic        step_req_q, step_req_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_q, pend_d;
    logic [7:0]  apple_q, apple_d;
    logic        apple_vld_q, apple_vld_d;
    logic [7:0]  score_q, score_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        pause_pend_q, pause_pend_d;
    logic [7:0]  cand_q, cand_d;
    logic [3:0]  seg_q, seg_d;

    logic [39:0] dec_w;
    logic [31:0] base_w;
    logic [31:0] period_w;
    logic [3:0]  press_w;
    logic [3:0]  legal_w;
    logic [1:0]  pend_arb_w;
    logic [7:0]  units_w;
    logic        cand_ok_w;
    logic [7:0]  seg_w;
    logic        seg_hit_w;
    logic        pause_eff_w;

    // Step period shrinks with score but never underflows or drops below the floor.
    assign dec_w = 40'(score_q) * 40'(SPEED_DEC);

    always_comb begin
        base_w = '0;
        if (dec_w < 40'(TICK_DIV)) begin
            base_w = TICK_DIV - dec_w[31:0];
        end
        period_w = (base_w < MIN_DIV) ? MIN_DIV : base_w;
    end

    // Bit index equals the direction code; reversals of the committed direction are masked first.
    assign press_w = {btn_right, btn_left, btn_down, btn_up};
    assign legal_w = press_w & ~(4'b0001 << (dir_q ^ 2'd1));

    always_comb begin
        pend_arb_w = pend_q;
        if (legal_w[0])      pend_arb_w = 2'd0;
        else if (legal_w[1]) pend_arb_w = 2'd1;
        else if (legal_w[2]) pend_arb_w = 2'd2;
        else if (legal_w[3]) pend_arb_w = 2'd3;
    end

    assign units_w   = cand_q % 8'd10;
    assign cand_ok_w = (cand_q >= 8'd12) && (cand_q <= 8'd89) && (units_w >= 8'd2);

    always_comb begin
        seg_w = 8'd0;
        for (int i = 0; i < 9; i++) begin
            if (seg_q == 4'(i)) seg_w = snake[71 - 8*i -: 8];
        end
    end

    assign seg_hit_w   = (seg_q < 4'd9) && (seg_w != 8'd0) && (seg_w == cand_q);
    assign pause_eff_w = pause_pend_q | pause;

    always_comb begin
        state_d      = state_q;
        step_req_d   = 1'b0;
        dir_d        = dir_q;
        pend_d       = pend_arb_w;
        apple_d      = apple_q;
        apple_vld_d  = apple_vld_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pause_pend_d = pause_pend_q;
        cand_d       = cand_q;
        seg_d        = seg_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d      = S_RUN;
                    dir_d        = DIR_RIGHT;
                    pend_d       = DIR_RIGHT;
                    apple_d      = APPLE_RST;
                    apple_vld_d  = 1'b1;
                    score_d      = 8'd0;
                    cnt_d        = '0;
                    lfsr_d       = 8'h01;
                    pause_pend_d = 1'b0;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_d = S_PAUSE;
                end else if (cnt_q == period_w - 32'd1) begin
                    step_req_d = 1'b1;
                    dir_d      = pend_arb_w;
                    state_d    = S_STEP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STEP: begin
                if (pause) pause_pend_d = 1'b1;
                if (step_done) begin
                    if (dead) begin
                        state_d = S_OVER;
                    end else if (ate) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        apple_vld_d = 1'b0;
                        cand_d      = lfsr_q;
                        seg_d       = 4'd0;
                        state_d     = S_PLACE;
                    end else begin
                        cnt_d        = '0;
                        state_d      = pause_eff_w ? S_PAUSE : S_RUN;
                        pause_pend_d = 1'b0;
                    end
                end
            end
            S_PLACE: begin
                if (pause) pause_pend_d = 1'b1;
                if (!cand_ok_w || seg_hit_w) begin
                    cand_d = lfsr_q;
                    seg_d  = 4'd0;
                end else if (seg_q == 4'd9) begin
                    apple_d      = cand_q;
                    apple_vld_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = pause_eff_w ? S_PAUSE : S_RUN;
                    pause_pend_d = 1'b0;
                end else begin
                    seg_d = seg_q + 4'd1;
                end
            end
            S_PAUSE: begin
                if (pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_req_q   <= 1'b0;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            apple_q      <= APPLE_RST;
            apple_vld_q  <= 1'b1;
            score_q      <= 8'd0;
            cnt_q        <= '0;
            lfsr_q       <= 8'h01;
            pause_pend_q <= 1'b0;
            cand_q       <= 8'd0;
            seg_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            step_req_q   <= step_req_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            apple_q      <= apple_d;
            apple_vld_q  <= apple_vld_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            pause_pend_q <= pause_pend_d;
            cand_q       <= cand_d;
            seg_q        <= seg_d;
        end
    end

    assign step_req  = step_req_q;
    assign dir       = dir_q;
    assign apple     = apple_q;
    assign apple_vld = apple_vld_q;
    assign score     = score_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_snake_game_sched.sv
// Bench for snake_game_sched: cycle model of the game rules plus directed scenarios.
module tb_snake_game_sched;

    localparam int TD = 8;
    localparam int SD = 2;
    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        start = 1'b0, pause = 1'b0;
    logic [71:0] snake;
    logic        step_done = 1'b0, ate = 1'b0, dead = 1'b0;
    logic        step_req;
    logic [1:0]  dir;
    logic [7:0]  apple;
    logic        apple_vld;
    logic [7:0]  score;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    snake_game_sched #(.TICK_DIV(TD), .SPEED_DEC(SD), .MIN_DIV(MD)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .start(start), .pause(pause), .snake(snake),
        .step_done(step_done), .ate(ate), .dead(dead),
        .step_req(step_req), .dir(dir), .apple(apple), .apple_vld(apple_vld),
        .score(score), .state_o(state_o)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state (0 idle, 1 run, 2 step, 3 place, 4 pause, 5 over)
    int m_state = 0, m_cnt = 0, m_score = 0, m_dir = 3, m_pend = 3;
    int m_apple = 89, m_vld = 1, m_req = 0, m_pp = 0, m_place_cyc = 0;
    int opp[4] = '{1, 0, 3, 2};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int s);
        int p;
        p = TD - s * SD;
        if (p < MD) p = MD;
        return p;
    endfunction

    function automatic int cell_ok(input int c);
        return (c >= 12 && c <= 89 && (c % 10) >= 2) ? 1 : 0;
    endfunction

    function automatic int in_snake(input int c);
        int b;
        for (int k = 0; k < 9; k++) begin
            b = int'(snake[8*k +: 8]);
            if (b != 0 && b == c) return 1;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        int np;
        np = m_pend;
        if (btn_up && opp[m_dir] != 0)         np = 0;
        else if (btn_down && opp[m_dir] != 1)  np = 1;
        else if (btn_left && opp[m_dir] != 2)  np = 2;
        else if (btn_right && opp[m_dir] != 3) np = 3;
        m_req = 0;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_score = 0; m_dir = 3; m_pend = 3;
            m_apple = 89; m_vld = 1; m_pp = 0;
        end else begin
            m_pend = np;
            case (m_state)
                0, 5: if (start) begin
                    m_state = 1; m_cnt = 0; m_score = 0; m_dir = 3; m_pend = 3;
                    m_apple = 89; m_vld = 1; m_pp = 0;
                end
                1: begin
                    if (pause) m_state = 4;
                    else if (m_cnt == period_of(m_score) - 1) begin
                        m_req = 1; m_dir = np; m_state = 2;
                    end else m_cnt++;
                end
                2: begin
                    if (pause) m_pp = 1;
                    if (step_done) begin
                        if (dead) m_state = 5;
                        else if (ate) begin
                            if (m_score < 255) m_score++;
                            m_vld = 0; m_state = 3; m_place_cyc = 0;
                        end else begin
                            m_cnt = 0; m_state = m_pp ? 4 : 1; m_pp = 0;
                        end
                    end
                end
                3: begin
                    if (pause) m_pp = 1;
                    m_place_cyc++;
                end
                4: if (pause) m_state = 1;
                default: m_state = 0;
            endcase
        end
    end

    // Placement ends at a cycle the rules leave open; accept it when the apple reappears and check it.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_state == 3 && apple_vld) begin
                check("apple_cell_valid", cell_ok(int'(apple)), 1);
                check("apple_not_on_body", in_snake(int'(apple)), 0);
                check("place_latency_ok", (m_place_cyc <= 2550) ? 1 : 0, 1);
                m_apple = int'(apple); m_vld = 1; m_cnt = 0;
                m_state = m_pp ? 4 : 1; m_pp = 0;
            end
            check("state", int'(state_o), m_state);
            check("step_req", int'(step_req), m_req);
            check("dir", int'(dir), m_dir);
            check("score", int'(score), m_score);
            check("apple_vld", int'(apple_vld), m_vld);
            check("apple", int'(apple), m_apple);
        end
    end

    task automatic wait_step(output int runs);
        int i;
        runs = 0;
        i = 0;
        while (!step_req && i < 200) begin
            if (state_o == 3'd1) runs++;
            @(negedge clk);
            i++;
        end
        check("step_req_seen", int'(step_req), 1);
    endtask

    task automatic respond(input logic a, input logic d);
        step_done = 1'b1; ate = a; dead = d;
        @(negedge clk);
        step_done = 1'b0; ate = 1'b0; dead = 1'b0;
    endtask

    task automatic wait_place();
        int i;
        i = 0;
        while (!apple_vld && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("place_done", int'(apple_vld), 1);
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        int r;
        int seen;
        snake = {8'd45, 8'd44, 8'd43, 8'd33, 8'd23, 8'd22, 8'd0, 8'd0, 8'd0};
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_state", int'(state_o), 0);
        check("rst_apple", int'(apple), 89);
        check("rst_dir", int'(dir), 3);
        rst = 1'b0;
        @(negedge clk);

        start = 1'b1; @(negedge clk); start = 1'b0;
        check("start_run", int'(state_o), 1);
        wait_step(r);
        check("period_score0", r, 8);
        check("first_dir", int'(dir), 3);
        respond(1'b0, 1'b0);
        wait_step(r);
        check("period_again", r, 8);
        respond(1'b0, 1'b0);

        btn_left = 1'b1; @(negedge clk); btn_left = 1'b0;
        wait_step(r);
        check("reverse_ignored", int'(dir), 3);
        respond(1'b0, 1'b0);
        btn_up = 1'b1; btn_left = 1'b1; @(negedge clk); btn_up = 1'b0; btn_left = 1'b0;
        wait_step(r);
        check("up_over_left", int'(dir), 0);
        respond(1'b1, 1'b0);
        check("place_state", int'(state_o), 3);
        check("vld_low_in_place", int'(apple_vld), 0);
        wait_place();
        wait_step(r);
        check("period_score1", r, 6);
        respond(1'b1, 1'b0);
        wait_place();
        wait_step(r);
        check("period_score2", r, 4);
        respond(1'b1, 1'b0);
        check("score_three", int'(score), 3);
        wait_place();
        wait_step(r);
        check("period_floor", r, 4);
        respond(1'b0, 1'b0);

        // pause mid-count: counter must resume from the held value
        @(negedge clk); @(negedge clk);
        pulse_pause();
        check("paused", int'(state_o), 4);
        repeat (3) @(negedge clk);
        check("still_paused", int'(state_o), 4);
        pulse_pause();
        wait_step(r);
        check("held_count", r, 2);

        pulse_pause();
        respond(1'b0, 1'b0);
        check("pend_pause_taken", int'(state_o), 4);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (step_req) seen = 1;
        end
        check("no_extra_req", seen, 0);
        pulse_pause();
        wait_step(r);
        check("resume_period", r, 4);

        respond(1'b1, 1'b1);
        check("dead_over", int'(state_o), 5);
        check("dead_score", int'(score), 3);
        repeat (3) @(negedge clk);
        pulse_pause();
        check("pause_ignored_over", int'(state_o), 5);
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("restart_run", int'(state_o), 1);
        check("restart_score", int'(score), 0);
        check("restart_apple", int'(apple), 89);
        wait_step(r);
        check("restart_period", r, 8);

        respond(1'b1, 1'b0);
        check("place_before_rst", int'(state_o), 3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_place_state", int'(state_o), 0);
        check("rst_in_place_vld", int'(apple_vld), 1);
        check("rst_in_place_apple", int'(apple), 89);
        check("rst_in_place_score", int'(score), 0);
        check("rst_in_place_req", int'(step_req), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
